// File: rtl/ahb_arbiter_if.sv
// AHB arbiter request/grant bundle: masters drive requests and transfer status,
// the arbiter (slave modport) returns the one-hot grant, owner index and lock flag.
interface ahb_arbiter_if #(
  parameter int NUM_MASTERS = 4
);
  logic [NUM_MASTERS-1:0] hbusreq;
  logic [NUM_MASTERS-1:0] hlock;
  logic [1:0]             htrans;
  logic                   hready;
  logic [NUM_MASTERS-1:0] hgrant;
  logic [3:0]             hmaster;
  logic                   hmastlock;

  modport master (
    output hbusreq, hlock, htrans, hready,
    input  hgrant, hmaster, hmastlock
  );

  modport slave (
    input  hbusreq, hlock, htrans, hready,
    output hgrant, hmaster, hmastlock
  );
endinterface

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter with locked-transfer handling and burst protection.
// Fixed priority by default; define ARB_ROUND_ROBIN_EN for round-robin selection.
module ahb_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic        hclk,
  input  logic        hreset,
  ahb_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_ARB       = 2'd0,
    ST_LOCKED    = 2'd1,
    ST_LOCK_TAIL = 2'd2
  } state_t;

  localparam logic [1:0] HTRANS_BUSY = 2'b01;
  localparam logic [1:0] HTRANS_SEQ  = 2'b11;

  localparam logic [NUM_MASTERS-1:0] DEFAULT_GRANT =
    {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;
  localparam logic [3:0] DEFAULT_IDX = 4'(DEFAULT_MASTER);

  state_t                 r_state;
  logic [NUM_MASTERS-1:0] r_hgrant;
  logic [3:0]             r_hmaster;

  logic [NUM_MASTERS-1:0] w_winner;
  logic [3:0]             w_grant_idx;
  logic                   w_burst_cont;
  logic                   w_mastlock;
  logic                   w_lock_req;

  // An ongoing burst (SEQ/BUSY) must never lose the bus mid-transfer.
  assign w_burst_cont = (bus.htrans == HTRANS_SEQ) || (bus.htrans == HTRANS_BUSY);
  assign w_mastlock   = |(r_hgrant & bus.hlock);
  // A lock only counts when the owner also requests the bus.
  assign w_lock_req   = |(r_hgrant & bus.hlock & bus.hbusreq);

  always_comb begin
    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    w_grant_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (r_hgrant[i]) w_grant_idx = w_grant_idx | 4'(i);
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  logic [3:0] r_rr_ptr;
  logic [3:0] w_winner_idx;
  logic       w_found;

  // Search from the slot after the last requesting winner, wrapping once.
  always_comb begin : rr_search
    int idx;
    w_winner     = DEFAULT_GRANT;
    w_winner_idx = DEFAULT_IDX;
    w_found      = 1'b0;
    idx          = 0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      idx = int'(r_rr_ptr) + 1 + k;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!w_found && bus.hbusreq[idx]) begin
        w_found           = 1'b1;
        w_winner          = '0;
        w_winner[idx]     = 1'b1;
        w_winner_idx      = 4'(idx);
      end
    end
  end
`else
  // Lowest index wins; scanning downward lets the lowest requester overwrite last.
  always_comb begin
    w_winner = DEFAULT_GRANT;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (bus.hbusreq[i]) begin
        w_winner    = '0;
        w_winner[i] = 1'b1;
      end
    end
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state   <= ST_ARB;
      r_hgrant  <= DEFAULT_GRANT;
      r_hmaster <= DEFAULT_IDX;
`ifdef ARB_ROUND_ROBIN_EN
      r_rr_ptr  <= '0;
`endif
    end else if (bus.hready) begin
      r_hmaster <= w_grant_idx;
      case (r_state)
        ST_ARB: begin
          if (w_lock_req) begin
            r_state <= ST_LOCKED;
          end else if (!w_burst_cont) begin
            r_hgrant <= w_winner;
`ifdef ARB_ROUND_ROBIN_EN
            if (w_found) r_rr_ptr <= w_winner_idx;
`endif
          end
        end
        ST_LOCKED: begin
          if (!w_mastlock) r_state <= ST_LOCK_TAIL;
        end
        // Grant is held one extra ready cycle to cover the last locked data phase.
        ST_LOCK_TAIL: r_state <= ST_ARB;
        default:      r_state <= ST_ARB;
      endcase
    end
  end

  assign bus.hgrant    = r_hgrant;
  assign bus.hmaster   = r_hmaster;
  assign bus.hmastlock = w_mastlock;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed self-checking bench for ahb_arbiter (4 masters, default master 0).
// Covers reset, priority, bursts, locking, stalls and the selected arbitration policy.
module tb_ahb_arbiter;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  logic hclk = 1'b0;
  logic hreset;
  int   checks   = 0;
  int   failures = 0;

  ahb_arbiter_if #(.NUM_MASTERS(4)) bus ();

  ahb_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(0)) dut (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus)
  );

  always #5 hclk = ~hclk;

  task tick();
    @(posedge hclk);
    #1;
  endtask

  task test_reset();
    hreset = 1'b1; bus.hbusreq = '0; bus.hlock = '0; bus.htrans = IDLE; bus.hready = 1'b1;
    tick(); tick();
    checks++; if (bus.hgrant !== 4'b0001) begin failures++; $display("FAIL reset_grant: got %b want 0001", bus.hgrant); end
    checks++; if (bus.hmaster !== 4'd0) begin failures++; $display("FAIL reset_hmaster: got %0d want 0", bus.hmaster); end
    hreset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.hgrant !== 4'b0001 || bus.hmaster !== 4'd0) begin
        failures++; $display("FAIL idle_default[%0d]: got grant %b master %0d want 0001/0", i, bus.hgrant, bus.hmaster);
      end
    end
  endtask

  task test_priority();
    bus.hbusreq = 4'b0110;
    tick();
    checks++; if (bus.hgrant !== 4'b0010) begin failures++; $display("FAIL prio_grant1: got %b want 0010", bus.hgrant); end
    checks++; if (bus.hmaster !== 4'd0) begin failures++; $display("FAIL prio_master_lag: got %0d want 0", bus.hmaster); end
    tick();
    checks++; if (bus.hmaster !== 4'd1) begin failures++; $display("FAIL prio_master1: got %0d want 1", bus.hmaster); end
    bus.hbusreq = 4'b0100;
    tick();
    checks++; if (bus.hgrant !== 4'b0100) begin failures++; $display("FAIL prio_grant2: got %b want 0100", bus.hgrant); end
    tick();
    checks++; if (bus.hmaster !== 4'd2) begin failures++; $display("FAIL prio_master2: got %0d want 2", bus.hmaster); end
    bus.hbusreq = 4'b0000;
    tick();
    checks++; if (bus.hgrant !== 4'b0001) begin failures++; $display("FAIL prio_default: got %b want 0001", bus.hgrant); end
  endtask

  task test_burst();
    bus.hbusreq = 4'b0100; bus.htrans = IDLE;
    tick();
    checks++; if (bus.hgrant !== 4'b0100) begin failures++; $display("FAIL burst_setup: got %b want 0100", bus.hgrant); end
    bus.htrans = NONSEQ;
    tick();
    bus.htrans = SEQ; bus.hbusreq = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.hgrant !== 4'b0100) begin failures++; $display("FAIL burst_seq_hold[%0d]: got %b want 0100", i, bus.hgrant); end
    end
    bus.htrans = BUSY;
    tick();
    checks++; if (bus.hgrant !== 4'b0100) begin failures++; $display("FAIL burst_busy_hold: got %b want 0100", bus.hgrant); end
    bus.htrans = IDLE; bus.hready = 1'b0;
    tick();
    checks++; if (bus.hgrant !== 4'b0100) begin failures++; $display("FAIL burst_stall_hold: got %b want 0100", bus.hgrant); end
    bus.hready = 1'b1;
    tick();
    checks++; if (bus.hgrant !== 4'b0001) begin failures++; $display("FAIL burst_end: got %b want 0001", bus.hgrant); end
  endtask

  task test_lock();
    // Lock without request from the owner must not freeze the grant.
    bus.hbusreq = 4'b0100; bus.hlock = 4'b0001;
    tick();
    checks++; if (bus.hgrant !== 4'b0100) begin failures++; $display("FAIL lock_ignored: got %b want 0100", bus.hgrant); end
    bus.hbusreq = 4'b1000; bus.hlock = 4'b1000;
    tick();
    checks++; if (bus.hgrant !== 4'b1000) begin failures++; $display("FAIL lock_grant: got %b want 1000", bus.hgrant); end
    checks++; if (bus.hmastlock !== 1'b1) begin failures++; $display("FAIL lock_mastlock: got %b want 1", bus.hmastlock); end
    bus.hbusreq = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.hgrant !== 4'b1000) begin failures++; $display("FAIL lock_frozen[%0d]: got %b want 1000", i, bus.hgrant); end
    end
    checks++; if (bus.hmaster !== 4'd3) begin failures++; $display("FAIL lock_hmaster: got %0d want 3", bus.hmaster); end
    bus.hlock = 4'b0000;
    #1;
    checks++; if (bus.hmastlock !== 1'b0) begin failures++; $display("FAIL lock_drop_mastlock: got %b want 0", bus.hmastlock); end
    tick();
    checks++; if (bus.hgrant !== 4'b1000) begin failures++; $display("FAIL lock_tail_hold: got %b want 1000", bus.hgrant); end
    tick();
    checks++; if (bus.hgrant !== 4'b1000) begin failures++; $display("FAIL lock_tail_exit: got %b want 1000", bus.hgrant); end
    tick();
    checks++; if (bus.hgrant !== 4'b0001) begin failures++; $display("FAIL lock_release: got %b want 0001", bus.hgrant); end
  endtask

  task test_stall_reset();
    logic [3:0] reqs [5];
    reqs = '{4'b0001, 4'b0011, 4'b1000, 4'b0000, 4'b1111};
    bus.hbusreq = 4'b0100;
    tick(); tick();
    checks++; if (bus.hgrant !== 4'b0100 || bus.hmaster !== 4'd2) begin
      failures++; $display("FAIL stall_setup: got %b/%0d want 0100/2", bus.hgrant, bus.hmaster);
    end
    bus.hready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.hbusreq = reqs[i];
      tick();
      checks++; if (bus.hgrant !== 4'b0100 || bus.hmaster !== 4'd2) begin
        failures++; $display("FAIL stall_hold[%0d]: got %b/%0d want 0100/2", i, bus.hgrant, bus.hmaster);
      end
    end
    bus.hready = 1'b1; bus.hbusreq = 4'b0100; bus.hlock = 4'b0100;
    tick();
    bus.hbusreq = 4'b0001;
    tick();
    checks++; if (bus.hgrant !== 4'b0100) begin failures++; $display("FAIL stall_locked: got %b want 0100", bus.hgrant); end
    hreset = 1'b1; bus.hready = 1'b0;
    tick();
    checks++; if (bus.hgrant !== 4'b0001 || bus.hmaster !== 4'd0) begin
      failures++; $display("FAIL reset_in_lock: got %b/%0d want 0001/0", bus.hgrant, bus.hmaster);
    end
    hreset = 1'b0; bus.hready = 1'b1; bus.hbusreq = 4'b1000; bus.hlock = 4'b0000;
    tick();
    checks++; if (bus.hgrant !== 4'b1000) begin failures++; $display("FAIL first_arb_after_reset: got %b want 1000", bus.hgrant); end
  endtask

  task test_policy();
    hreset = 1'b1; bus.hbusreq = 4'b0000; bus.hlock = 4'b0000; bus.htrans = IDLE;
    tick();
    hreset = 1'b0; bus.hbusreq = 4'b1111;
`ifdef ARB_ROUND_ROBIN_EN
    begin
      logic [3:0] exp [4];
      exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
      for (int i = 0; i < 4; i++) begin
        tick();
        checks++; if (bus.hgrant !== exp[i]) begin failures++; $display("FAIL rr_cycle[%0d]: got %b want %b", i, bus.hgrant, exp[i]); end
      end
      bus.hbusreq = 4'b0000;
      tick();
      bus.hbusreq = 4'b1111;
      tick();
      checks++; if (bus.hgrant !== 4'b0010) begin failures++; $display("FAIL rr_ptr_kept: got %b want 0010", bus.hgrant); end
    end
`else
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.hgrant !== 4'b0001) begin failures++; $display("FAIL fixed_all_req[%0d]: got %b want 0001", i, bus.hgrant); end
    end
    bus.hbusreq = 4'b1010;
    tick();
    checks++; if (bus.hgrant !== 4'b0010) begin failures++; $display("FAIL fixed_1010: got %b want 0010", bus.hgrant); end
`endif
  endtask

  initial begin
    test_reset();
    test_priority();
    test_burst();
    test_lock();
    test_stall_reset();
    test_policy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_arbiter.md
AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 4, number of requesters, legal range 2..16.
REQ-002 Parameter DEFAULT_MASTER, default 0, master granted when nobody requests, legal range 0..NUM_MASTERS-1.
REQ-003 hclk  in  1  sole clock; all state updates on rising edge.
REQ-004 hreset  in  1  reset, synchronous, active-high.
REQ-005 hbusreq  in  NUM_MASTERS  bus request per master, bit i = master i.
REQ-006 hlock  in  NUM_MASTERS  locked-access request per master.
REQ-007 htrans  in  2  current transfer type of the bus owner: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-008 hready  in  1  slave ready; the current transfer completes this cycle.
REQ-009 hgrant  out  NUM_MASTERS  one-hot grant, registered.
REQ-010 hmaster  out  4  index of the master owning the address phase, registered.
REQ-011 hmastlock  out  1  lock indication of the granted master, combinational.

Function
REQ-012 hgrant SHALL be exactly one-hot in every cycle, including during reset.
REQ-013 Arbitration SHALL occur in a cycle only when hready=1, state=ARB and htrans is not SEQ or BUSY; otherwise hgrant SHALL hold.
REQ-014 Winner selection SHALL use fixed priority, lowest index highest, over hbusreq bits.
REQ-015 With hbusreq all zero at an arbitration point, hgrant SHALL select DEFAULT_MASTER.
REQ-016 The winner SHALL appear on hgrant at the rising edge following the arbitration cycle, i.e. 1-cycle latency.
REQ-017 hmaster SHALL load index i at the rising edge where hgrant[i]=1 and hready=1, and SHALL hold otherwise.
REQ-018 hmastlock SHALL equal hlock[i] of the currently granted master i in the same cycle.
REQ-019 States: ARB, LOCKED, LOCK_TAIL.
REQ-020 ARB -> LOCKED when the granted master has hlock=1 and hready=1.
REQ-021 In LOCKED, hgrant SHALL be frozen regardless of higher-priority requests.
REQ-022 LOCKED -> LOCK_TAIL when the granted master drops hlock and hready=1.
REQ-023 LOCK_TAIL -> ARB after the next cycle with hready=1; this holds grant for the final locked data phase.
REQ-024 A granted master deasserting hbusreq mid-burst (htrans=SEQ/BUSY) SHALL keep the grant until the burst ends with htrans IDLE/NONSEQ and hready=1.
REQ-025 hready=0 SHALL stall all state, hgrant and hmaster updates.
REQ-026 Simultaneous hlock assertion by several requesters SHALL be resolved by the same priority as hbusreq; a requester's hlock without hbusreq SHALL be ignored for arbitration.

Reset
REQ-027 While hreset=1 at a rising edge: hgrant <= one-hot(DEFAULT_MASTER), hmaster <= DEFAULT_MASTER, state <= ARB, round-robin pointer <= 0.
REQ-028 Reset asserted mid-burst or in LOCKED SHALL abandon the ownership and apply REQ-027 at that edge, regardless of hready.
REQ-029 After reset release, the first arbitration SHALL be possible in the first cycle satisfying REQ-013.

Configuration
REQ-030 Macro ARB_ROUND_ROBIN_EN, when defined, SHALL replace REQ-014 with round-robin: the search starts at (last winner index + 1) mod NUM_MASTERS and wraps; the pointer updates only when a requesting master wins.
REQ-031 Without ARB_ROUND_ROBIN_EN, fixed priority per REQ-014 and no pointer register exists.
REQ-032 REQ-015, the lock rules and all timing SHALL be identical in both builds.

Verification
REQ-033 Reset, then hbusreq=0000, hready=1 -> hgrant=0001 and hmaster=0 throughout.
REQ-034 hbusreq=0110, htrans=IDLE, hready=1 -> next cycle hgrant=0010; one cycle later hmaster=1.
REQ-035 Master 2 granted, htrans=SEQ burst, hbusreq=0001 -> hgrant stays 0100 until htrans=IDLE with hready=1, then hgrant=0001.
REQ-036 Master 3 granted with hlock[3]=1, hbusreq=1001 -> hmastlock=1 and hgrant=1000 frozen; hlock[3] drops, then after one more hready=1 cycle -> hgrant=0001.
REQ-037 hready=0 for 5 cycles with changing hbusreq -> hgrant and hmaster unchanged; hreset=1 during LOCKED -> hgrant=0001 at the next edge.
REQ-038 With ARB_ROUND_ROBIN_EN, hbusreq=1111 held with IDLE transfers -> grants cycle 0010, 0100, 1000, 0001.
